mem_port_responder: RTL and testbench



---
 rtl/mem_bus_pkg.sv | 22 ++
 rtl/mem_stall_lfsr.sv | 28 ++
 rtl/mem_port_responder.sv | 137 +++++++++++++
 tb/tb_mem_port_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the req/gnt/err/rdata memory bus responders.
package mem_bus_pkg;

    localparam int unsigned MEM_ADDR_W_DEFAULT = 64;
    localparam int unsigned MEM_DATA_W_DEFAULT = 64;

    localparam int unsigned LFSR_W  = 16;
    localparam int unsigned DELAY_W = 3;

    // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    function automatic int unsigned strb_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_stall_lfsr.sv
// 16-bit Fibonacci LFSR that supplies the raw grant-stall delay field.
module mem_stall_lfsr
    import mem_bus_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [DELAY_W-1:0] delay_field
);

    logic [LFSR_W-1:0] lfsr;
    logic              feedback;

    assign feedback = ^(lfsr & LFSR_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else if (en) begin
            lfsr <= {lfsr[LFSR_W-2:0], feedback};
        end
    end

    assign delay_field = lfsr[DELAY_W-1:0];

endmodule

// File: rtl/mem_port_responder.sv
// Bounded-latency memory slave for one core port: RAM, range errors and
// pseudo-random grant stalls, responding one cycle after acceptance.
module mem_port_responder
    import mem_bus_pkg::*;
#(
    parameter int unsigned            MEM_ADDR_W = MEM_ADDR_W_DEFAULT,
    parameter int unsigned            MEM_DATA_W = MEM_DATA_W_DEFAULT,
    parameter logic [MEM_ADDR_W-1:0]  BASE_ADDR  = MEM_ADDR_W'(64'h0000_0000_0000_1000),
    parameter int unsigned            DEPTH      = 256,
    parameter int unsigned            MAX_DELAY  = 4,
    parameter logic [LFSR_W-1:0]      LFSR_SEED  = 16'hACE1
) (
    input  logic                               g_clk,
    input  logic                               g_resetn,
    input  logic                               stall_en,
    input  logic                               mem_req,
    input  logic [MEM_ADDR_W-1:0]              mem_addr,
    input  logic                               mem_wen,
    input  logic [strb_width(MEM_DATA_W)-1:0]  mem_strb,
    input  logic [MEM_DATA_W-1:0]              mem_wdata,
    output logic                               mem_gnt,
    output logic                               mem_err,
    output logic [MEM_DATA_W-1:0]              mem_rdata
);

    localparam int unsigned STRB_W = strb_width(MEM_DATA_W);
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam logic [MEM_ADDR_W-1:0] SPAN = MEM_ADDR_W'(DEPTH * STRB_W);

    state_t              state, state_n;
    logic [DELAY_W-1:0]  cnt, cnt_n;
    logic [DELAY_W-1:0]  raw_delay, delay;
    logic                gnt_c;
    logic                accept;

    logic [MEM_ADDR_W-1:0] off;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic [MEM_DATA_W-1:0] ram [DEPTH];
    logic [MEM_DATA_W-1:0] cur_word;
    logic [MEM_DATA_W-1:0] merged_word;

    mem_stall_lfsr #(
        .SEED        (LFSR_SEED)
    ) u_lfsr (
        .clk         (g_clk),
        .rst_n       (g_resetn),
        .en          (stall_en),
        .delay_field (raw_delay)
    );

    // Sampled stall length; zero when stalls are disabled
    always_comb begin
        delay = '0;
        if (stall_en) begin
            delay = (raw_delay > DELAY_W'(MAX_DELAY)) ? DELAY_W'(MAX_DELAY) : raw_delay;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gnt_c   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    if (delay == '0) begin
                        gnt_c = 1'b1;
                    end else begin
                        cnt_n   = delay - DELAY_W'(1);
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!mem_req) begin
                    // Abandoned request: forget the count, resample next time
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == '0) begin
                    gnt_c   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - DELAY_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Reset gates the combinational grant so it drops immediately
    assign mem_gnt = gnt_c & g_resetn;
    assign accept  = mem_req & mem_gnt;

    assign off      = mem_addr - BASE_ADDR;
    assign in_range = (mem_addr >= BASE_ADDR) && (off < SPAN);
    assign idx      = off[OFF_W +: IDX_W];
    assign cur_word = ram[idx];

    for (genvar b = 0; b < STRB_W; b++) begin : g_merge
        assign merged_word[8*b +: 8] = mem_strb[b] ? mem_wdata[8*b +: 8] : cur_word[8*b +: 8];
    end

    always_ff @(posedge g_clk) begin
        if (accept && mem_wen && in_range) begin
            ram[idx] <= merged_word;
        end
    end

    // Registered response; rdata holds between responses, err pulses
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            mem_err   <= 1'b0;
            mem_rdata <= '0;
        end else if (accept) begin
            mem_err   <= ~in_range;
            mem_rdata <= (!mem_wen && in_range) ? cur_word : '0;
        end else begin
            mem_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_responder.sv
// Scoreboard bench for mem_port_responder: driver queues expected responses
// at grant time, a negedge monitor pops and compares them.
module tb_mem_port_responder;

    localparam logic [63:0] BASE  = 64'h1000;
    localparam int          DEPTH = 256;
    localparam logic [63:0] SPAN  = 64'd2048;

    typedef struct packed {
        logic        err;
        logic [63:0] rdata;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_en = 1'b0;
    logic        mem_req = 1'b0;
    logic [63:0] mem_addr = '0;
    logic        mem_wen = 1'b0;
    logic [7:0]  mem_strb = '0;
    logic [63:0] mem_wdata = '0;
    logic        mem_gnt;
    logic        mem_err;
    logic [63:0] mem_rdata;

    resp_t       exp_q [$];
    logic [63:0] model [DEPTH];
    int          checks = 0;
    int          failures = 0;
    bit          saw0 = 1'b0;
    bit          saw4 = 1'b0;
    bit          pend = 1'b0;
    logic [63:0] last_rdata = '0;

    always #5 clk = ~clk;

    mem_port_responder #(
        .MEM_ADDR_W (64),
        .MEM_DATA_W (64),
        .BASE_ADDR  (64'h1000),
        .DEPTH      (256),
        .MAX_DELAY  (4),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .g_clk      (clk),
        .g_resetn   (rst_n),
        .stall_en   (stall_en),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_strb   (mem_strb),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_err    (mem_err),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: response cycle follows each observed acceptance
    always @(negedge clk) begin
        resp_t e;
        if (!rst_n) begin
            pend       = 1'b0;
            last_rdata = '0;
        end else begin
            if (pend) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 64'(mem_err), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_err", 64'(mem_err), 64'(e.err));
                    chk("resp_rdata", mem_rdata, e.rdata);
                    last_rdata = e.rdata;
                end
            end else begin
                chk("idle_err", 64'(mem_err), 64'd0);
                chk("idle_rdata_hold", mem_rdata, last_rdata);
            end
            pend = mem_req && mem_gnt;
        end
    end

    task automatic do_req(input logic [63:0] addr, input logic wen, input logic [7:0] strb,
                          input logic [63:0] wdata, input int exp_wait,
                          input bit use_hand, input resp_t hand);
        int          waits;
        bit          got;
        resp_t       e;
        logic [63:0] off;
        int          idx;
        mem_req   = 1'b1;
        mem_addr  = addr;
        mem_wen   = wen;
        mem_strb  = strb;
        mem_wdata = wdata;
        waits = 0;
        got   = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (mem_gnt === 1'b1) begin
                got = 1'b1;
                break;
            end
            waits++;
        end
        if (!got) begin
            chk("gnt_timeout", 64'd0, 64'd1);
            mem_req = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        off = addr - BASE;
        e.err   = 1'b0;
        e.rdata = '0;
        if (addr < BASE || off >= SPAN) begin
            e.err = 1'b1;
        end else begin
            idx = int'(off >> 3);
            if (wen) begin
                for (int b = 0; b < 8; b++) begin
                    if (strb[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end else begin
                e.rdata = model[idx];
            end
        end
        exp_q.push_back(use_hand ? hand : e);
        if (exp_wait >= 0) chk("wait_exact", 64'(waits), 64'(exp_wait));
        else               chk("wait_bound", 64'(waits <= 4), 64'd1);
        if (waits == 0) saw0 = 1'b1;
        if (waits == 4) saw4 = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_req = 1'b0;
        mem_wen = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resp_t       nr;
        logic [63:0] a;
        nr = '0;

        // Reset values, and grant held off while reset is asserted
        repeat (2) @(posedge clk);
        #1;
        mem_req = 1'b1;
        #1;
        chk("rst_gnt", 64'(mem_gnt), 64'd0);
        chk("rst_err", 64'(mem_err), 64'd0);
        chk("rst_rdata", mem_rdata, 64'd0);
        chk("rst_lfsr", 64'(dut.u_lfsr.lfsr), 64'hACE1);
        mem_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed, no stalls
        do_req(BASE + 64'h10, 1'b1, 8'hFF, 64'h1122334455667788, 0, 1'b1, '{1'b0, 64'h0});
        do_req(BASE + 64'h10, 1'b0, 8'h00, 64'h0, 0, 1'b1, '{1'b0, 64'h1122334455667788});
        do_req(BASE + 64'h10, 1'b1, 8'h0F, 64'hAAAAAAAABBBBBBBB, 0, 1'b1, '{1'b0, 64'h0});
        do_req(BASE + 64'h10, 1'b0, 8'h00, 64'h0, 0, 1'b1, '{1'b0, 64'h11223344BBBBBBBB});
        do_req(BASE + 64'h15, 1'b0, 8'h00, 64'h0, 0, 1'b1, '{1'b0, 64'h11223344BBBBBBBB});
        do_req(BASE + SPAN, 1'b0, 8'h00, 64'h0, 0, 1'b1, '{1'b1, 64'h0});
        do_req(64'h0FF8, 1'b0, 8'h00, 64'h0, 0, 1'b1, '{1'b1, 64'h0});
        do_req(BASE, 1'b1, 8'hFF, 64'h0123456789ABCDEF, 0, 1'b1, '{1'b0, 64'h0});
        do_req(BASE + SPAN, 1'b1, 8'hFF, 64'hDEAD, 0, 1'b1, '{1'b1, 64'h0});
        do_req(BASE, 1'b0, 8'h00, 64'h0, 0, 1'b1, '{1'b0, 64'h0123456789ABCDEF});
        do_req(BASE + SPAN - 8, 1'b1, 8'hFF, 64'hCAFEF00D12345678, 0, 1'b1, '{1'b0, 64'h0});
        do_req(BASE + SPAN - 1, 1'b0, 8'h00, 64'h0, 0, 1'b1, '{1'b0, 64'hCAFEF00D12345678});
        idle();

        // Preload every word so the random phase reads known data
        for (int i = 0; i < DEPTH; i++) begin
            do_req(BASE + 64'(i * 8), 1'b1, 8'hFF, {$urandom, $urandom}, 0, 1'b0, nr);
        end
        idle();

        // Random traffic with stalls
        stall_en = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 7))
                0:       a = BASE + SPAN + 64'($urandom_range(0, 255) * 8);
                1:       a = BASE - 64'($urandom_range(1, 256) * 8);
                default: a = BASE + 64'($urandom_range(0, 255) * 8) + 64'($urandom_range(0, 7));
            endcase
            do_req(a, 1'($urandom_range(0, 1)), 8'($urandom), {$urandom, $urandom}, -1, 1'b0, nr);
        end
        idle();
        chk("saw_wait0", 64'(saw0), 64'd1);
        chk("saw_wait4", 64'(saw4), 64'd1);

        // Reset in the middle of a WAIT (seed gives d=1)
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        mem_req  = 1'b1;
        mem_wen  = 1'b0;
        mem_addr = BASE + 64'h10;
        @(negedge clk);
        chk("wait_entry_gnt", 64'(mem_gnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midwait_rst_gnt", 64'(mem_gnt), 64'd0);
        chk("midwait_rst_lfsr", 64'(dut.u_lfsr.lfsr), 64'hACE1);
        chk("midwait_rst_err", 64'(mem_err), 64'd0);
        @(posedge clk);
        #1;
        chk("midwait_rst_gnt2", 64'(mem_gnt), 64'd0);
        stall_en = 1'b0;
        mem_req  = 1'b0;
        rst_n    = 1'b1;
        do_req(BASE + 64'h10, 1'b0, 8'h00, 64'h0, 0, 1'b0, nr);
        idle();

        // Request dropped in WAIT (LFSR one step past seed gives d=3)
        stall_en = 1'b1;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mem_req  = 1'b1;
        mem_addr = BASE + 64'h10;
        @(negedge clk);
        chk("drop_idle_gnt", 64'(mem_gnt), 64'd0);
        @(posedge clk);
        #1;
        chk("drop_in_wait", 64'(dut.state), 64'd1);
        mem_req = 1'b0;
        @(negedge clk);
        chk("drop_gnt", 64'(mem_gnt), 64'd0);
        @(posedge clk);
        #1;
        chk("drop_state_idle", 64'(dut.state), 64'd0);
        do_req(BASE + 64'h10, 1'b0, 8'h00, 64'h0, -1, 1'b0, nr);
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
